// File: rtl/adc_display_driver.sv
// adc_display_driver: four-digit multiplexed seven-segment driver with periodic value snapshot
// and leading-zero blanking; all outputs are registered and active-low.
module adc_display_driver #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int UPDATE_CYCLES  = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] display_value,
    input  logic        blank_en,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam int UW = $clog2(UPDATE_CYCLES);

    logic [RW-1:0] ref_cnt;
    logic [UW-1:0] upd_cnt;
    logic [1:0]    digit_idx;
    logic [15:0]   snapshot;
    logic          ref_done, upd_done, blanked;
    logic [3:0]    nib, an_nxt;
    logic [15:0]   upper;
    logic [6:0]    seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        ref_done = ref_cnt == RW'(REFRESH_CYCLES - 1);
        upd_done = upd_cnt == UW'(UPDATE_CYCLES - 1);
        nib      = snapshot[{digit_idx, 2'b00} +: 4];
        // Nibbles at and above the active digit, used for leading-zero detection
        upper    = snapshot >> {digit_idx, 2'b00};
        blanked  = blank_en && digit_idx != 2'd0 && upper == 16'h0;
        an_nxt   = blanked ? 4'b1111 : ~(4'b0001 << digit_idx);
        seg_nxt  = blanked ? 7'h7F : decode(nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt   <= '0;
            upd_cnt   <= '0;
            digit_idx <= 2'd0;
            snapshot  <= 16'h0;
            an        <= 4'b1111;
            seg       <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            ref_cnt   <= ref_done ? '0 : ref_cnt + 1'b1;
            upd_cnt   <= upd_done ? '0 : upd_cnt + 1'b1;
            digit_idx <= ref_done ? digit_idx + 2'd1 : digit_idx;
            snapshot  <= upd_done ? display_value : snapshot;
            an        <= an_nxt;
            seg       <= seg_nxt;
            dp        <= blanked | ~dp_en[digit_idx];
        end
    end
endmodule

// File: tb/tb_adc_display_driver.sv
// tb_adc_display_driver: directed vector checks of the display driver with REFRESH=4, UPDATE=16.
module tb_adc_display_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] display_value = 16'h0;
    logic        blank_en = 1'b0;
    logic [3:0]  dp_en = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t tv[$];

    adc_display_driver #(.REFRESH_CYCLES(4), .UPDATE_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .display_value(display_value), .blank_en(blank_en),
        .dp_en(dp_en), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        tests++;
        if (an !== ea || seg !== es || dp !== ed) begin
            fails++;
            $display("FAIL %s (cycle %0d): got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                     name, cyc, an, seg, dp, ea, es, ed);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 4'b1111, 7'h7F, 1'b1);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic run_vecs(input string name);
        for (int i = 0; i < tv.size(); i++) begin
            while (cyc < tv[i].n) step();
            chk(name, tv[i].an, tv[i].seg, tv[i].dp);
        end
        tv.delete();
    endtask

    task automatic add(input int n, input logic [3:0] a, input logic [6:0] s, input logic d);
        vec_t v;
        v.n = n; v.an = a; v.seg = s; v.dp = d;
        tv.push_back(v);
    endtask

    initial begin
        // Scan of 1234 without blanking
        display_value = 16'h1234;
        do_reset();
        add(1,  4'b1110, 7'h40, 1'b1);
        add(8,  4'b1101, 7'h40, 1'b1);
        add(16, 4'b0111, 7'h40, 1'b1);
        add(17, 4'b1110, 7'h19, 1'b1);
        add(21, 4'b1101, 7'h30, 1'b1);
        add(25, 4'b1011, 7'h24, 1'b1);
        add(29, 4'b0111, 7'h79, 1'b1);
        add(33, 4'b1110, 7'h19, 1'b1);
        run_vecs("scan_1234");

        // Leading-zero blanking of 0045, then unblanked
        display_value = 16'h0045;
        blank_en = 1'b1;
        do_reset();
        add(17, 4'b1110, 7'h12, 1'b1);
        add(21, 4'b1101, 7'h19, 1'b1);
        add(25, 4'b1111, 7'h7F, 1'b1);
        add(29, 4'b1111, 7'h7F, 1'b1);
        run_vecs("blank_0045");
        blank_en = 1'b0;
        add(41, 4'b1011, 7'h40, 1'b1);
        add(45, 4'b0111, 7'h40, 1'b1);
        run_vecs("noblank_0045");

        // All-zero value: only digit 0 lit, dp only there
        display_value = 16'h0000;
        blank_en = 1'b1;
        dp_en = 4'b1111;
        do_reset();
        add(1,  4'b1110, 7'h40, 1'b0);
        add(5,  4'b1111, 7'h7F, 1'b1);
        add(9,  4'b1111, 7'h7F, 1'b1);
        add(13, 4'b1111, 7'h7F, 1'b1);
        add(17, 4'b1110, 7'h40, 1'b0);
        run_vecs("zero_blank");

        // Input toggling between updates must never reach the display
        blank_en = 1'b0;
        dp_en = 4'b0000;
        do_reset();
        begin
            int saw_f = 0;
            for (int n = 1; n <= 48; n++) begin
                display_value = (n % 16 == 0) ? 16'hABCD : ((n % 2 == 1) ? 16'hABCD : 16'hFFFF);
                step();
                if (n >= 17 && seg === 7'h0E) saw_f++;
                case (n)
                    17, 33:  chk("toggle_d", 4'b1110, 7'h21, 1'b1);
                    21:      chk("toggle_c", 4'b1101, 7'h46, 1'b1);
                    25:      chk("toggle_b", 4'b1011, 7'h03, 1'b1);
                    29, 45:  chk("toggle_a", 4'b0111, 7'h08, 1'b1);
                    default: ;
                endcase
            end
            tests++;
            if (saw_f != 0) begin
                fails++;
                $display("FAIL no_ffff: got %0d cycles showing F, expected 0", saw_f);
            end
        end

        // Reset pulse while digit 2 is active
        display_value = 16'h1234;
        do_reset();
        add(26, 4'b1011, 7'h24, 1'b1);
        run_vecs("pre_midreset");
        reset = 1'b1;
        step();
        chk("midreset", 4'b1111, 7'h7F, 1'b1);
        reset = 1'b0;
        cyc = 0;
        add(1,  4'b1110, 7'h40, 1'b1);
        add(4,  4'b1110, 7'h40, 1'b1);
        add(5,  4'b1101, 7'h40, 1'b1);
        add(16, 4'b0111, 7'h40, 1'b1);
        add(17, 4'b1110, 7'h19, 1'b1);
        run_vecs("post_midreset");

        // Decimal point only on digit 1
        dp_en = 4'b0010;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            int d;
            step();
            d = ((n - 1) / 4) % 4;
            chk("dp_digit1", ~(4'b0001 << d), (n >= 17) ? 7'h19 : 7'h40, (d == 1) ? 1'b0 : 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adc_display_driver.md
ADC_DISPLAY_DRIVER -- requirements
Module: adc_display_driver

Interface
REQ-001 Parameter REFRESH_CYCLES, default 100000: clk cycles each digit stays active; legal values are 2 or more.
REQ-002 Parameter UPDATE_CYCLES, default 25000000: clk cycles between display-value snapshots; legal values are 2 or more.
REQ-003 clk  input  1  system clock; the only clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 display_value  input  16  four nibbles to show, from the ADC subsystem output mux; nibble k drives digit k, and digit 0 is the rightmost.
REQ-006 blank_en  input  1  1 = blank leading zeros (BCD mode); 0 = show all four digits.
REQ-007 dp_en  input  4  decimal-point enable per digit; bit k belongs to digit k.
REQ-008 an  output  4  digit anodes, active-low.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal-point segment, active-low.

Function
REQ-011 Update counter: counts 0..UPDATE_CYCLES-1 and wraps to 0; in the cycle it equals UPDATE_CYCLES-1, the snapshot register shall load display_value.
REQ-012 display_value changes between update terminal counts shall have no effect on the outputs.
REQ-013 Refresh counter: counts 0..REFRESH_CYCLES-1 and wraps to 0; in the cycle it equals REFRESH_CYCLES-1, digit_idx (2 bits) shall advance 0->1->2->3->0.
REQ-014 Output registers (registered, latency 1): the outputs at cycle t+1 shall be a function of digit_idx, snapshot, blank_en and dp_en sampled at cycle t.
REQ-015 Active digit k, not blanked: an = all ones except bit k = 0; seg = decode(snapshot[4k+3:4k]); dp = ~dp_en[k].
REQ-016 Decode table (hex, active-low gfedcba):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
REQ-017 Blanking, when blank_en=1: digit k (k>=1) is blanked if every nibble at positions k..3 of the snapshot is zero; digit 0 is never blanked.
REQ-018 A blanked digit shall drive an=1111, seg=7F and dp=1, regardless of dp_en.
REQ-019 blank_en=0: no digit is ever blanked; a value of 0000 shows four zeros.
REQ-020 Simultaneous terminal counts: if the update and refresh terminal counts occur in the same cycle, both take effect in that cycle; the next output uses the new snapshot and the new digit_idx.
REQ-021 Exactly one anode shall be low in any cycle after the first post-reset cycle, unless the active digit is blanked.
REQ-022 Counters shall be wide enough for the parameter values, with no overflow before the terminal count.

Reset
REQ-023 While reset=1 on a clock edge, the following shall be loaded:
- update counter and refresh counter = 0
- digit_idx = 0
- snapshot = 0000
- an = 1111, seg = 7F, dp = 1
REQ-024 Reset asserted mid-scan or mid-update shall abort the scan or update; in the first cycle after reset deasserts, counting restarts from 0.
REQ-025 After reset deasserts, the first visible digit is digit 0 showing '0' (seg = 40), and the snapshot stays 0000 until the first update terminal count.

Verification (REFRESH_CYCLES=4, UPDATE_CYCLES=16)
REQ-026 Reset, then display_value=1234, blank_en=0, dp_en=0:
- before cycle 16, digit 0 shows seg=40
- after the first update, an steps 1110,1101,1011,0111 every 4 cycles
- seg steps 19,30,24,79 in the same order.
REQ-027 Snapshot 0045, blank_en=1: digits 3 and 2 drive an=1111, seg=7F; digits 1 and 0 show 19 and 12. With blank_en=0, digits 3 and 2 show 40.
REQ-028 Snapshot 0000, blank_en=1: only digit 0 is lit, showing 40; dp_en=1111 lights dp only on digit 0.
REQ-029 display_value toggles ABCD/FFFF every cycle except at the terminal count, where it is ABCD: the display shows only ABCD (seg 08,03,46,21 across digits 3..0), never FFFF.
REQ-030 Reset asserted for 1 cycle during digit 2 of a scan: next cycle an=1111, seg=7F; then digit 0 resumes with seg=40 and the counters restart from 0.
REQ-031 Scan digit 1 with dp_en=0010 and blank_en=0: dp=0 only while an=1101.
